// File: rtl/imem_arb_pkg.sv
// Shared types for the instruction-ROM arbiter between the two fetch stages.
package imem_arb_pkg;

  localparam int NUM_CORES = 2;

  typedef logic core_id_t;

  // Outstanding ROM read: valid flag plus the core that owns the returning data.
  typedef struct packed {
    logic     v;
    core_id_t id;
  } pend_t;

endpackage

// File: rtl/imem_arbiter_rr_arb2.sv
// Two-way round-robin grant with a one-bit priority pointer.
// The pointer favours the core that was not served most recently.
module rr_arb2
  import imem_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] elig,
  output logic [NUM_CORES-1:0] gnt,
  output logic                 prio_nxt
);

  logic prio_q;

  // Grant the lone eligible core, or the prioritised one on a tie; then point past the winner.
  always_comb begin
    gnt      = '0;
    prio_nxt = prio_q;
    unique case (elig)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    if (gnt[0]) begin
      prio_nxt = 1'b1;
    end else if (gnt[1]) begin
      prio_nxt = 1'b0;
    end
  end

  // Pointer register; core 0 wins the first tie after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_nxt;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares one single-port synchronous instruction ROM between two fetch stages:
// combinational grant and address mux, one-cycle-late response routing with
// flush kill, and a saturating contention counter.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] req,
  input  logic [ADDR_W-1:0]    addr0,
  input  logic [ADDR_W-1:0]    addr1,
  input  logic [NUM_CORES-1:0] flush,
  input  logic [NUM_CORES-1:0] hlt,
  output logic [NUM_CORES-1:0] gnt,
  output logic [NUM_CORES-1:0] stall,
  output logic [NUM_CORES-1:0] rvalid,
  output logic [DATA_W-1:0]    rdata,
  output logic                 mem_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic [CNT_W-1:0]     contention_cnt
);

  logic [NUM_CORES-1:0] elig;
  logic                 prio_nxt;
  pend_t                pend_p1;
  logic [CNT_W-1:0]     cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // ---- stage p0: arbitration and ROM address (combinational) ----
  // Reset also masks eligibility so no grant or stall leaks out while it is held.
  assign elig = req & ~hlt & ~flush & {NUM_CORES{~reset}};

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .elig     (elig),
    .gnt      (gnt),
    .prio_nxt (prio_nxt)
  );

  assign mem_en = |gnt;
  assign stall  = req & ~hlt & ~gnt & {NUM_CORES{~reset}};

  // Route the granted core's PC to the ROM; drive zero when idle.
  always_comb begin
    mem_addr = '0;
    if (gnt[0]) begin
      mem_addr = addr0;
    end else if (gnt[1]) begin
      mem_addr = addr1;
    end
  end

  // ---- stage p1: in-flight tracker ----
  // On a grant the pointer moves past the winner, so the winner is ~prio_nxt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_p1 <= '0;
    end else begin
      pend_p1.v <= mem_en;
      if (mem_en) begin
        pend_p1.id <= ~prio_nxt;
      end
    end
  end

  // Deliver the ROM word to its owner unless that core is flushing this cycle.
  always_comb begin
    rvalid = '0;
    if (pend_p1.v && !flush[pend_p1.id]) begin
      rvalid[pend_p1.id] = 1'b1;
    end
  end

  assign rdata = (|rvalid) ? mem_rdata : '0;

  // Count cycles where both cores competed; hold at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (elig == 2'b11) begin
      cnt_q <= sat_inc(cnt_q);
    end
  end

  assign contention_cnt = cnt_q;

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single-port synchronous instruction ROM between the two cores' fetch stages in the dual-core processor. Each cycle it grants at most one fetch request using round-robin priority, drives the ROM address, and routes the ROM's one-cycle-late read data back to the granted core. Non-granted cores get a stall. Per-core flush and halt inputs suppress wrong-path or halted fetches.

## Interface
Parameters:
- ADDR_W, 32, fetch address width (byte address)
- DATA_W, 32, instruction width
- CNT_W, 16, width of the contention counter

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req  in  2  fetch request per core (bit i = core i)
- addr0  in  ADDR_W  core 0 fetch PC
- addr1  in  ADDR_W  core 1 fetch PC
- flush  in  2  per-core flush: drops that core's in-flight and same-cycle fetch
- hlt  in  2  per-core halt: masks that core's requests while high
- gnt  out  2  one-hot or zero; combinational grant this cycle
- stall  out  2  req & ~hlt & ~gnt; core must hold its PC
- rvalid  out  2  registered; instruction for core i is on rdata this cycle
- rdata  out  DATA_W  instruction returned (zero when rvalid == 0)
- mem_en  out  1  ROM read enable (= |gnt)
- mem_addr  out  ADDR_W  address of the granted core, 0 when idle
- mem_rdata  in  DATA_W  ROM data, valid the cycle after mem_en
- contention_cnt  out  CNT_W  saturating count of cycles in which both cores had an eligible request

## Operation
- Eligible request: elig[i] = req[i] & ~hlt[i] & ~flush[i].
- Arbitration:
  - Exactly one eligible core: that core is granted.
  - Both eligible: core prio is granted.
  - None eligible: gnt = 0, mem_en = 0.
- Priority pointer prio (1 bit): after any grant to core i, prio <= ~i. With no grant, prio holds. Reset value is 0, so core 0 wins first.
- In-flight tracker, registered: pend_v, pend_id. On a grant, pend_v <= 1 and pend_id <= granted core. Otherwise pend_v <= 0.
- Response, in the cycle after the grant:
  - rvalid[pend_id] = pend_v & ~flush[pend_id].
  - rdata = mem_rdata when any rvalid bit is set, else 0.
  - A flush arriving in the response cycle kills the response. rvalid stays 0 and the core must re-request.
- contention_cnt increments when elig == 2'b11. It saturates at all-ones and never wraps.
- hlt high with an outstanding response: the response is still delivered. Only new requests are masked.

## Timing
- Grant latency is 0 cycles (combinational from req/hlt/flush/prio). Data latency is 1 cycle after the grant.
- Throughput is one fetch per cycle in aggregate. Under continuous dual requests the grants strictly alternate, so neither core waits more than 1 consecutive cycle.
- A stalled core keeps req high and its address stable. The arbiter does not register the address; mem_addr is taken from the granted core in the same cycle.
- Simultaneous grant to core i and flush of core i cannot occur, because a flush removes eligibility.
- A flush of core i in the same cycle as a grant to core j does not disturb j.
- Reset, asynchronous, including mid-operation: gnt = 0, stall = 0, rvalid = 0, rdata = 0, mem_en = 0, mem_addr = 0, prio = 0, pend_v = 0, contention_cnt = 0. Any in-flight response is discarded. The first post-reset grant follows the normal rules.

## Structure
- Package imem_arb_pkg holds:
  - NUM_CORES = 2
  - typedef logic core_id_t
  - typedef struct packed {logic v; core_id_t id;} pend_t
- Sub-module rr_arb2: the 2-way round-robin grant plus priority pointer (inputs elig, outputs gnt and next prio, pointer state inside).
- The top level holds the address mux, pending tracker, response routing and contention counter.

## Test plan
- Reset, then core 0 only requests addr0 = 0x10 for 3 cycles, with the ROM returning 0xAAAA0010 → gnt = 01 each cycle, mem_addr = 0x10, and rvalid = 01 with rdata = 0xAAAA0010 one cycle after each grant.
- Both cores request continuously (addr0 = 0x20, addr1 = 0x40) → gnt sequence 01, 10, 01, 10. stall is 10, 01, 10, 01. contention_cnt increments 1 per cycle.
- Core 1 granted at cycle N, flush[1] asserted at N+1 → rvalid = 00 at N+1 and rdata = 0. Core 0 requesting at N+1 is granted.
- hlt[0] = 1 with both requesting → gnt = 10 every cycle, stall[0] = 0, and contention_cnt holds.
- Assert reset the cycle after a grant to core 0 → rvalid stays 0 and contention_cnt = 0. After release, a dual request grants core 0 first.
- Force contention_cnt to all-ones via a long dual request (use CNT_W = 4 with 20 cycles) → the counter stays at 0xF.
